// File: rtl/axis_frame_checker.sv
// AXI4-Stream sink that checks a {frame_id, beat_idx} counter pattern and TLAST placement,
// applying optional LFSR backpressure and keeping statistics plus a first-error capture.
module axis_frame_checker #(
    parameter int          DATA_W      = 32,
    parameter int          KEEP_W      = DATA_W / 8,
    parameter int          USER_W      = 1,
    parameter int          FRAME_BEATS = 8,
    parameter int          CNT_W       = 32,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tlast,
    input  logic [USER_W-1:0] s_axis_tuser,
    input  logic              bp_en,
    input  logic              clr_stats,
    output logic              locked,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  data_err_cnt,
    output logic [CNT_W-1:0]  last_err_cnt,
    output logic              err_sticky,
    output logic [31:0]       first_err_exp,
    output logic [31:0]       first_err_got
);

    typedef enum logic {HUNT, LOCK} state_t;

    state_t            r_state, w_stateNext;
    logic [15:0]       r_lfsr;
    logic              r_ready;
    logic [15:0]       r_expFrame;
    logic [15:0]       r_expBeat;
    logic [CNT_W-1:0]  r_beatCnt, r_frameCnt, r_dataErrCnt, r_lastErrCnt;
    logic              r_errSticky;
    logic [31:0]       r_firstExp, r_firstGot;

    logic              w_accept;
    logic              w_dataErr;
    logic              w_lastErr;
    logic              w_lfsrFb;
    logic [DATA_W-1:0] w_exp;
    logic              w_unusedUser;

    assign w_unusedUser = ^s_axis_tuser;
    assign w_accept     = s_axis_tvalid & r_ready;
    // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1, shifting right
    assign w_lfsrFb     = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    always_comb begin
        w_stateNext = r_state;
        w_exp       = '0;
        w_exp[31:0] = {r_expFrame, r_expBeat};
        w_dataErr   = 1'b0;
        w_lastErr   = 1'b0;
        if (w_accept) begin
            if (r_state == HUNT) begin
                w_stateNext = LOCK;
            end else begin
                w_dataErr = (s_axis_tdata != w_exp) || (s_axis_tkeep != '1);
                w_lastErr = s_axis_tlast != (r_expBeat == 16'(FRAME_BEATS - 1));
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= HUNT;
            r_lfsr  <= LFSR_SEED;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_lfsr  <= {w_lfsrFb, r_lfsr[15:1]};
            r_ready <= ~bp_en | r_lfsr[0];
        end
    end

    // Expectation follows the received beat so a single bad beat never cascades
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_expFrame <= '0;
            r_expBeat  <= '0;
        end else if (w_accept) begin
            if (s_axis_tlast) begin
                r_expFrame <= s_axis_tdata[31:16] + 16'd1;
                r_expBeat  <= '0;
            end else begin
                r_expFrame <= s_axis_tdata[31:16];
                r_expBeat  <= s_axis_tdata[15:0] + 16'd1;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_beatCnt    <= '0;
            r_frameCnt   <= '0;
            r_dataErrCnt <= '0;
            r_lastErrCnt <= '0;
            r_errSticky  <= 1'b0;
            r_firstExp   <= '0;
            r_firstGot   <= '0;
        end else if (clr_stats) begin
            r_beatCnt    <= '0;
            r_frameCnt   <= '0;
            r_dataErrCnt <= '0;
            r_lastErrCnt <= '0;
            r_errSticky  <= 1'b0;
            r_firstExp   <= '0;
            r_firstGot   <= '0;
        end else begin
            r_beatCnt    <= satInc(r_beatCnt, w_accept);
            r_frameCnt   <= satInc(r_frameCnt, w_accept & s_axis_tlast);
            r_dataErrCnt <= satInc(r_dataErrCnt, w_dataErr);
            r_lastErrCnt <= satInc(r_lastErrCnt, w_lastErr);
            if (!r_errSticky && (w_dataErr || w_lastErr)) begin
                r_errSticky <= 1'b1;
                r_firstExp  <= w_exp[31:0];
                r_firstGot  <= s_axis_tdata[31:0];
            end
        end
    end

    assign s_axis_tready = r_ready;
    assign locked        = (r_state == LOCK);
    assign beat_cnt      = r_beatCnt;
    assign frame_cnt     = r_frameCnt;
    assign data_err_cnt  = r_dataErrCnt;
    assign last_err_cnt  = r_lastErrCnt;
    assign err_sticky    = r_errSticky;
    assign first_err_exp = r_firstExp;
    assign first_err_got = r_firstGot;

endmodule

// File: tb/tb_axis_frame_checker.sv
// Directed bench for axis_frame_checker: a driver queues per-beat expected error flags and a
// monitor checks counter deltas after every accepted beat; milestone totals are checked inline.
module tb_axis_frame_checker;

    localparam int DATA_W      = 32;
    localparam int KEEP_W      = 4;
    localparam int USER_W      = 1;
    localparam int FRAME_BEATS = 8;
    localparam int CNT_W       = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic [USER_W-1:0] tuser;
    logic              bpEn;
    logic              clrStats;
    logic              locked;
    logic [CNT_W-1:0]  beatCnt, frameCnt, dataErrCnt, lastErrCnt;
    logic              errSticky;
    logic [31:0]       firstErrExp, firstErrGot;

    typedef struct {
        logic dErr;
        logic lErr;
        logic clr;
    } beatExp_t;

    beatExp_t sbQ[$];
    int checks      = 0;
    int failures    = 0;
    int stallCycles = 0;

    axis_frame_checker #(
        .DATA_W(DATA_W), .KEEP_W(KEEP_W), .USER_W(USER_W),
        .FRAME_BEATS(FRAME_BEATS), .CNT_W(CNT_W), .LFSR_SEED(16'hACE1)
    ) dut (
        .aclk(clk), .areset(rst),
        .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tdata(tdata),
        .s_axis_tkeep(tkeep), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
        .bp_en(bpEn), .clr_stats(clrStats), .locked(locked),
        .beat_cnt(beatCnt), .frame_cnt(frameCnt), .data_err_cnt(dataErrCnt),
        .last_err_cnt(lastErrCnt), .err_sticky(errSticky),
        .first_err_exp(firstErrExp), .first_err_got(firstErrGot)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drives one beat (called 1 time unit after a rising edge) and returns 1 unit after it is accepted
    task automatic applyStimulus(input logic [31:0] data, input logic last, input logic keepOk,
                                 input logic dErr, input logic lErr, input logic clr);
        int       waitCycles;
        beatExp_t e;
        waitCycles = 0;
        tvalid   = 1'b1;
        tdata    = data;
        tlast    = last;
        tkeep    = keepOk ? 4'hF : 4'h7;
        clrStats = clr;
        forever begin
            @(negedge clk);
            if (tready) break;
            stallCycles++;
            waitCycles++;
            if (waitCycles > 200) begin
                checks++;
                failures++;
                $display("[TB] FAIL ready timeout: beat %h never accepted", data);
                tvalid   = 1'b0;
                clrStats = 1'b0;
                return;
            end
        end
        e.dErr = dErr;
        e.lErr = lErr;
        e.clr  = clr;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        tvalid   = 1'b0;
        clrStats = 1'b0;
    endtask

    task automatic sendBeats(input int frame, input int firstBeat, input int lastBeat);
        for (int b = firstBeat; b <= lastBeat; b++)
            applyStimulus({16'(frame), 16'(b)}, b == FRAME_BEATS - 1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sendFrames(input int first, input int count);
        for (int f = first; f < first + count; f++)
            sendBeats(f, 0, FRAME_BEATS - 1);
    endtask

    task automatic resetDut();
        rst      = 1'b1;
        tvalid   = 1'b0;
        clrStats = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst tready", {31'b0, tready}, 32'd0);
        checkOutput("rst locked", {31'b0, locked}, 32'd0);
        checkOutput("rst beatCnt", beatCnt, 32'd0);
        checkOutput("rst frameCnt", frameCnt, 32'd0);
        checkOutput("rst dataErrCnt", dataErrCnt, 32'd0);
        checkOutput("rst lastErrCnt", lastErrCnt, 32'd0);
        checkOutput("rst errSticky", {31'b0, errSticky}, 32'd0);
        checkOutput("rst firstErrExp", firstErrExp, 32'd0);
        checkOutput("rst firstErrGot", firstErrGot, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic clearStats();
        clrStats = 1'b1;
        @(posedge clk);
        #1;
        clrStats = 1'b0;
    endtask

    logic [31:0] pB, pF, pD, pL;
    logic        pLast;
    beatExp_t    mExp;

    // Monitor: each accepted beat pops its expected flags and checks the counter deltas
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tvalid && tready) begin
                pB    = beatCnt;
                pF    = frameCnt;
                pD    = dataErrCnt;
                pL    = lastErrCnt;
                pLast = tlast;
                @(posedge clk);
                #1;
                if (sbQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected accept: queue empty, beatCnt %0d", beatCnt);
                end else begin
                    mExp = sbQ.pop_front();
                    if (mExp.clr) begin
                        checkOutput("mon clr beatCnt", beatCnt, 32'd0);
                        checkOutput("mon clr frameCnt", frameCnt, 32'd0);
                        checkOutput("mon clr dataErrCnt", dataErrCnt, 32'd0);
                        checkOutput("mon clr lastErrCnt", lastErrCnt, 32'd0);
                        checkOutput("mon clr errSticky", {31'b0, errSticky}, 32'd0);
                    end else begin
                        checkOutput("mon beatCnt", beatCnt, pB + 32'd1);
                        checkOutput("mon frameCnt", frameCnt, pF + 32'(pLast));
                        checkOutput("mon dataErrCnt", dataErrCnt, pD + 32'(mExp.dErr));
                        checkOutput("mon lastErrCnt", lastErrCnt, pL + 32'(mExp.lErr));
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL global timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        rst      = 1'b1;
        tvalid   = 1'b0;
        tdata    = '0;
        tkeep    = '1;
        tlast    = 1'b0;
        tuser    = '0;
        bpEn     = 1'b0;
        clrStats = 1'b0;
        #1;
        resetDut();

        // Clean stream, no backpressure
        sendFrames(0, 100);
        checkOutput("t1 beatCnt", beatCnt, 32'd800);
        checkOutput("t1 frameCnt", frameCnt, 32'd100);
        checkOutput("t1 dataErrCnt", dataErrCnt, 32'd0);
        checkOutput("t1 lastErrCnt", lastErrCnt, 32'd0);
        checkOutput("t1 locked", {31'b0, locked}, 32'd1);

        // Same stream continuing under pseudo-random backpressure
        clearStats();
        checkOutput("clr beatCnt", beatCnt, 32'd0);
        checkOutput("clr locked kept", {31'b0, locked}, 32'd1);
        bpEn        = 1'b1;
        stallCycles = 0;
        sendFrames(100, 100);
        checkOutput("t2 beatCnt", beatCnt, 32'd800);
        checkOutput("t2 frameCnt", frameCnt, 32'd100);
        checkOutput("t2 dataErrCnt", dataErrCnt, 32'd0);
        checkOutput("t2 lastErrCnt", lastErrCnt, 32'd0);
        checkOutput("t2 stalls seen", {31'b0, stallCycles != 0}, 32'd1);
        bpEn = 1'b0;

        // Corrupted data beat, then resync on the following beat
        resetDut();
        sendFrames(0, 5);
        sendBeats(5, 0, 2);
        applyStimulus(32'h0005_00FF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t3 dataErrCnt", dataErrCnt, 32'd1);
        checkOutput("t3 errSticky", {31'b0, errSticky}, 32'd1);
        checkOutput("t3 firstErrExp", firstErrExp, 32'h0005_0003);
        checkOutput("t3 firstErrGot", firstErrGot, 32'h0005_00FF);
        applyStimulus(32'h0005_0004, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        sendBeats(5, 5, 7);
        sendFrames(6, 1);
        checkOutput("t3 final dataErrCnt", dataErrCnt, 32'd2);
        checkOutput("t3 final lastErrCnt", lastErrCnt, 32'd0);
        checkOutput("t3 final firstErrExp", firstErrExp, 32'h0005_0003);
        checkOutput("t3 final beatCnt", beatCnt, 32'd56);
        checkOutput("t3 final frameCnt", frameCnt, 32'd7);

        // Missing tlast, then a data error on the next frame's first beat, then clean
        resetDut();
        sendFrames(0, 2);
        sendBeats(2, 0, 6);
        applyStimulus(32'h0002_0007, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("t4 lastErrCnt", lastErrCnt, 32'd1);
        applyStimulus(32'h0003_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t4 dataErrCnt", dataErrCnt, 32'd1);
        sendBeats(3, 1, 7);
        sendFrames(4, 1);
        checkOutput("t4 final dataErrCnt", dataErrCnt, 32'd1);
        checkOutput("t4 final lastErrCnt", lastErrCnt, 32'd1);
        checkOutput("t4 firstErrExp", firstErrExp, 32'h0002_0007);
        checkOutput("t4 firstErrGot", firstErrGot, 32'h0002_0007);
        checkOutput("t4 beatCnt", beatCnt, 32'd40);
        checkOutput("t4 frameCnt", frameCnt, 32'd4);

        // Clear coincident with an erroring beat; expectation still follows that beat
        applyStimulus(32'h0005_0009, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t5 dataErrCnt", dataErrCnt, 32'd0);
        checkOutput("t5 errSticky", {31'b0, errSticky}, 32'd0);
        checkOutput("t5 firstErrExp", firstErrExp, 32'd0);
        applyStimulus(32'h0005_000A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h0005_000B, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h0005_000C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("t5 beatCnt", beatCnt, 32'd3);
        checkOutput("t5 keep dataErrCnt", dataErrCnt, 32'd1);
        checkOutput("t5 keep lastErrCnt", lastErrCnt, 32'd0);
        checkOutput("t5 keep errSticky", {31'b0, errSticky}, 32'd1);
        checkOutput("t5 keep firstErrExp", firstErrExp, 32'h0005_000C);
        checkOutput("t5 keep firstErrGot", firstErrGot, 32'h0005_000C);

        // Reset mid-frame, source restarts from zero
        resetDut();
        sendFrames(0, 1);
        sendBeats(1, 0, 3);
        resetDut();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t6 locked before accept", {31'b0, locked}, 32'd0);
        sendFrames(0, 3);
        checkOutput("t6 locked", {31'b0, locked}, 32'd1);
        checkOutput("t6 beatCnt", beatCnt, 32'd24);
        checkOutput("t6 frameCnt", frameCnt, 32'd3);
        checkOutput("t6 dataErrCnt", dataErrCnt, 32'd0);
        checkOutput("t6 lastErrCnt", lastErrCnt, 32'd0);
        checkOutput("t6 errSticky", {31'b0, errSticky}, 32'd0);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", sbQ.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
